// File: rtl/output_port_pkg.sv
// Shared constants for the MCU output-side peripheral.
//   OUT_FIFO_DEPTH : number of buffered OUT words (power of two, >= 2)
//   OUT_WORD_W     : register-file word width
//   lvl_w()        : width of an occupancy counter that can hold 0..depth
package output_port_pkg;

  localparam int OUT_FIFO_DEPTH = 4;
  localparam int OUT_WORD_W     = 16;

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/output_port_sync_fifo.sv
// sync_fifo: generic single-clock FIFO with a push/pop request interface.
// Requests are gated internally, so callers may assert them freely.
// Ports:
//   clk, rst         : clock, synchronous active-high reset (control state only)
//   push, push_data  : write request and word
//   pop              : read request (ignored when empty)
//   head_data        : memory[read pointer], combinational, no output register
//   empty, full      : occupancy flags derived from level
//   level            : current occupancy 0..DEPTH
module sync_fifo
  import output_port_pkg::*;
#(
  parameter int WIDTH = OUT_WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign pop_ok = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push_ok = push && (!full || pop_ok);

  assign head_data = mem[rd_ptr];

  // Storage is deliberately not reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/output_port.sv
// output_port: captures register-file words on OUT instructions and hands them
// to an external consumer over valid/ready. The core is never back-pressured:
// words arriving while the FIFO is full (and not draining) are dropped and
// recorded in a sticky overflow flag.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   wr_valid, wr_data      : OUT capture strobe and word from the control unit
//   port_valid, port_data  : head word presented to the consumer
//   port_ready             : consumer accepts head word when valid & ready
//   full, level            : FIFO occupancy status
//   overflow, overflow_clr : sticky drop flag and its clear
module output_port
  import output_port_pkg::*;
#(
  parameter int WIDTH = OUT_WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   port_valid,
  output logic [WIDTH-1:0]       port_data,
  input  logic                   port_ready,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  logic empty;
  logic pop_fire;
  logic drop;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (port_ready),
    .head_data (port_data),
    .empty     (empty),
    .full      (full),
    .level     (level)
  );

  assign port_valid = !empty;
  assign pop_fire   = port_valid && port_ready;
  assign drop       = wr_valid && full && !pop_fire;

  // A drop in the same cycle as a clear wins, so no lost word goes unreported.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_port.sv
module tb_output_port;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   wr_valid = 1'b0;
  logic [WIDTH-1:0]       wr_data = '0;
  logic                   port_valid;
  logic [WIDTH-1:0]       port_data;
  logic                   port_ready = 1'b0;
  logic                   full;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic                   overflow_clr = 1'b0;

  always #5 clk = ~clk;

  output_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .port_valid   (port_valid),
    .port_data    (port_data),
    .port_ready   (port_ready),
    .full         (full),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: a plain queue of buffered words plus the sticky flag.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf = 1'b0;
  // Scoreboard of accepted words, consumed by the monitor.
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Monitor: head word must match the oldest accepted word; pop on handshake.
  always @(negedge clk) begin
    if (!rst && port_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        check("head_data", 32'(port_data), 32'(exp_q[0]));
        if (port_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle: drive inputs, check status against the model, then
  // advance the model by the rules of push/pop/drop/overflow.
  task automatic step(input logic wv, input logic [WIDTH-1:0] wd, input logic rdy,
                      input logic clr, input logic r);
    int sz;
    bit pop;
    bit drop;
    wr_valid = wv; wr_data = wd; port_ready = rdy; overflow_clr = clr; rst = r;
    @(negedge clk);
    sz = mq.size();
    check("level",      32'(level),      32'(sz));
    check("full",       32'(full),       32'(sz == DEPTH));
    check("port_valid", 32'(port_valid), 32'(sz > 0));
    check("overflow",   32'(overflow),   32'(m_ovf));
    if (r) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = rdy && (sz > 0);
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (wv) begin
        if (sz < DEPTH || pop) begin
          mq.push_back(wd);
          exp_q.push_back(wd);
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;

    // Single OUT, held for 5 cycles with no consumer
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    idle(2, 1'b1);

    // Fill and drop
    for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Full with simultaneous push+pop
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 5; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b1);

    // Wrap-around with alternating push/pop
    for (int i = 0; i < 10; i++) begin
      step(1'b1, WIDTH'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end

    // Overflow priority over clear
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0AAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0BBB, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // Reset mid-operation with a concurrent write
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Randomized traffic with alternating consumer pressure
    for (int blk = 0; blk < 8; blk++) begin
      for (int k = 0; k < 50; k++) begin
        step(1'($urandom_range(0, 1)),
             WIDTH'($urandom),
             (blk[0]) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 63) == 0));
      end
    end

    idle(DEPTH + 2, 1'b1);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
